// File: rtl/countdown_timer_bcd_pkg.sv
// Shared definitions for the mm:ss BCD countdown timer: FSM encodings,
// BCD digit limits and preset validation.
package countdown_timer_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } timerStateT;

  localparam logic [3:0]  BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0]  BCD_MAX_TENS  = 4'd5;
  localparam logic [15:0] ZERO_TIME     = 16'h0000;

  // A mm or ss field is valid when tens <= 5 and units <= 9.
  function automatic logic isValidField(input logic [7:0] field);
    return (field[7:4] <= BCD_MAX_TENS) && (field[3:0] <= BCD_MAX_UNITS);
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// Single BCD down-counting digit; wraps 0 -> MAXV and flags a borrow to the
// next more-significant digit in the same cycle.
module bcd_down_digit #(
  parameter logic [3:0] MAXV = 4'd9
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow
);

  assign borrow = dec && (q == 4'd0);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      q <= 4'd0;
    end else if (load) begin
      q <= d;
    end else if (dec) begin
      q <= (q == 4'd0) ? MAXV : q - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// mm:ss BCD countdown timer: loads a preset, counts down on the shared 1 Hz
// tick, pulses DONE at 00:00 and then holds ALARM for ALARM_SECS ticks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | stopped; waits for START with a non-zero time
// ST_RUN   | decrementing once per EN tick
// ST_PAUSE | time frozen; START resumes
// ST_ALARM | expired at 00:00; ALARM high until ticks elapse or acknowledged
module countdown_timer_bcd
  import countdown_timer_bcd_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       EN,
  input  logic       LOAD,
  input  logic       START,
  input  logic       PAUSE,
  input  logic [7:0] PRESET_M,
  input  logic [7:0] PRESET_S,
  output logic [7:0] Q_M,
  output logic [7:0] Q_S,
  output logic       RUNNING,
  output logic       DONE,
  output logic       ALARM,
  output logic       LOAD_ERR
);

  timerStateT state;
  logic [7:0] alarmCnt;

  logic [3:0] secUnits, secTens, minUnits, minTens;
  logic       secUnitsBorrow, secTensBorrow, minUnitsBorrow, minTensBorrow;

  logic presetValid, loadOk, isZero, willZero, decEn;

  assign presetValid = isValidField(PRESET_M) && isValidField(PRESET_S);
  assign loadOk      = LOAD && presetValid;
  assign isZero      = ({minTens, minUnits, secTens, secUnits} == ZERO_TIME);
  assign willZero    = ({minTens, minUnits, secTens, secUnits} == 16'h0001);

  // LOAD and PAUSE both pre-empt a tick; START in RUN is a no-op so EN still counts.
  assign decEn = (state == ST_RUN) && EN && !LOAD && !PAUSE && !isZero;

  bcd_down_digit #(.MAXV(BCD_MAX_UNITS)) uSecUnits (
    .CP(CP), .nCR(nCR), .dec(decEn), .load(loadOk), .d(PRESET_S[3:0]),
    .q(secUnits), .borrow(secUnitsBorrow)
  );

  bcd_down_digit #(.MAXV(BCD_MAX_TENS)) uSecTens (
    .CP(CP), .nCR(nCR), .dec(secUnitsBorrow), .load(loadOk), .d(PRESET_S[7:4]),
    .q(secTens), .borrow(secTensBorrow)
  );

  bcd_down_digit #(.MAXV(BCD_MAX_UNITS)) uMinUnits (
    .CP(CP), .nCR(nCR), .dec(secTensBorrow), .load(loadOk), .d(PRESET_M[3:0]),
    .q(minUnits), .borrow(minUnitsBorrow)
  );

  bcd_down_digit #(.MAXV(BCD_MAX_TENS)) uMinTens (
    .CP(CP), .nCR(nCR), .dec(minUnitsBorrow), .load(loadOk), .d(PRESET_M[7:4]),
    .q(minTens), .borrow(minTensBorrow)
  );

  assign Q_M = {minTens, minUnits};
  assign Q_S = {secTens, secUnits};

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state    <= ST_IDLE;
      alarmCnt <= 8'd0;
      RUNNING  <= 1'b0;
      DONE     <= 1'b0;
      ALARM    <= 1'b0;
      LOAD_ERR <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      LOAD_ERR <= 1'b0;
      if (LOAD) begin
        if (presetValid) begin
          state    <= ST_IDLE;
          alarmCnt <= 8'd0;
          RUNNING  <= 1'b0;
          ALARM    <= 1'b0;
        end else begin
          LOAD_ERR <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (START && !isZero) begin
              state   <= ST_RUN;
              RUNNING <= 1'b1;
            end
          end
          ST_RUN: begin
            if (PAUSE) begin
              state   <= ST_PAUSE;
              RUNNING <= 1'b0;
            end else if (EN && (willZero || minTensBorrow)) begin
              state    <= ST_ALARM;
              RUNNING  <= 1'b0;
              ALARM    <= 1'b1;
              DONE     <= 1'b1;
              alarmCnt <= 8'(ALARM_SECS);
            end
          end
          ST_PAUSE: begin
            if (START && !PAUSE) begin
              state   <= ST_RUN;
              RUNNING <= 1'b1;
            end
          end
          ST_ALARM: begin
            if (PAUSE || START || (EN && alarmCnt <= 8'd1)) begin
              state    <= ST_IDLE;
              ALARM    <= 1'b0;
              alarmCnt <= 8'd0;
            end else if (EN) begin
              alarmCnt <= alarmCnt - 8'd1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            RUNNING <= 1'b0;
            ALARM   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd (ALARM_SECS=3): a vector table for
// the single-cycle behaviour plus sequences for long runs and async reset.
module tb_countdown_timer_bcd;

  logic       CP, nCR, EN, LOAD, START, PAUSE;
  logic [7:0] PRESET_M, PRESET_S, Q_M, Q_S;
  logic       RUNNING, DONE, ALARM, LOAD_ERR;

  int errors = 0;
  int checks = 0;

  countdown_timer_bcd #(.ALARM_SECS(3)) dut (
    .CP(CP), .nCR(nCR), .EN(EN), .LOAD(LOAD), .START(START), .PAUSE(PAUSE),
    .PRESET_M(PRESET_M), .PRESET_S(PRESET_S), .Q_M(Q_M), .Q_S(Q_S),
    .RUNNING(RUNNING), .DONE(DONE), .ALARM(ALARM), .LOAD_ERR(LOAD_ERR)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  typedef struct {
    logic ld, st, pa, en;
    logic [7:0] pm, ps;
    logic [7:0] eM, eS;
    logic eRun, eDone, eAlarm, eErr;
  } vecT;

  vecT vecs[$];

  function automatic vecT mk(logic ld, logic st, logic pa, logic en,
                             logic [7:0] pm, logic [7:0] ps,
                             logic [7:0] eM, logic [7:0] eS,
                             logic eRun, logic eDone, logic eAlarm, logic eErr);
    vecT v;
    v.ld = ld; v.st = st; v.pa = pa; v.en = en; v.pm = pm; v.ps = ps;
    v.eM = eM; v.eS = eS; v.eRun = eRun; v.eDone = eDone; v.eAlarm = eAlarm; v.eErr = eErr;
    return v;
  endfunction

  function automatic logic [15:0] toBcd(int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(string name, logic [7:0] eM, logic [7:0] eS,
                     logic eRun, logic eDone, logic eAlarm, logic eErr);
    logic [19:0] got, exp;
    got = {Q_M, Q_S, RUNNING, DONE, ALARM, LOAD_ERR};
    exp = {eM, eS, eRun, eDone, eAlarm, eErr};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got Q=%h:%h run=%b done=%b alarm=%b err=%b, expected Q=%h:%h run=%b done=%b alarm=%b err=%b",
               name, Q_M, Q_S, RUNNING, DONE, ALARM, LOAD_ERR, eM, eS, eRun, eDone, eAlarm, eErr);
    end
  endtask

  task automatic drive(logic ld, logic st, logic pa, logic en, logic [7:0] pm, logic [7:0] ps);
    LOAD = ld; START = st; PAUSE = pa; EN = en; PRESET_M = pm; PRESET_S = ps;
  endtask

  task automatic cycle();
    @(posedge CP);
    #1;
  endtask

  initial begin
    logic [15:0] expQ;
    int doneCount;

    // Reset with every input asserted
    nCR = 1'b0;
    drive(1, 1, 1, 1, 8'h12, 8'h34);
    #100;
    chk("reset_hold", 8'h00, 8'h00, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    @(negedge CP);
    nCR = 1'b1;
    repeat (3) cycle();
    chk("reset_release_idle", 8'h00, 8'h00, 0, 0, 0, 0);

    vecs.push_back(mk(1,0,0,0, 8'h01,8'h02, 8'h01,8'h02, 0,0,0,0)); // load 01:02
    vecs.push_back(mk(0,1,0,0, 8'h00,8'h00, 8'h01,8'h02, 1,0,0,0)); // start
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h01,8'h01, 1,0,0,0));
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h01,8'h00, 1,0,0,0));
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h59, 1,0,0,0)); // minute borrow
    vecs.push_back(mk(0,0,0,0, 8'h00,8'h00, 8'h00,8'h59, 1,0,0,0)); // no tick
    vecs.push_back(mk(0,0,1,1, 8'h00,8'h00, 8'h00,8'h59, 0,0,0,0)); // pause drops tick
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h59, 0,0,0,0)); // frozen
    vecs.push_back(mk(0,1,0,1, 8'h00,8'h00, 8'h00,8'h59, 1,0,0,0)); // resume, no dec
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h58, 1,0,0,0));
    vecs.push_back(mk(1,0,0,0, 8'h6A,8'h00, 8'h00,8'h58, 1,0,0,1)); // bad minutes
    vecs.push_back(mk(0,0,0,0, 8'h00,8'h00, 8'h00,8'h58, 1,0,0,0)); // err is one cycle
    vecs.push_back(mk(1,0,0,0, 8'h00,8'h75, 8'h00,8'h58, 1,0,0,1)); // bad seconds
    vecs.push_back(mk(1,0,0,0, 8'h10,8'h00, 8'h10,8'h00, 0,0,0,0)); // valid load in RUN
    vecs.push_back(mk(0,1,0,0, 8'h00,8'h00, 8'h10,8'h00, 1,0,0,0));
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h09,8'h59, 1,0,0,0)); // tens-of-minutes borrow
    vecs.push_back(mk(1,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0)); // load 00:00
    vecs.push_back(mk(0,1,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0)); // start at zero ignored
    vecs.push_back(mk(1,0,0,0, 8'h00,8'h02, 8'h00,8'h02, 0,0,0,0));
    vecs.push_back(mk(0,1,0,1, 8'h00,8'h00, 8'h00,8'h02, 1,0,0,0)); // start+en from idle
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h01, 1,0,0,0));
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 0,1,1,0)); // expiry
    vecs.push_back(mk(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,1,0)); // done one cycle
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 0,0,1,0)); // alarm 1 of 3
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 0,0,1,0)); // alarm 2 of 3
    vecs.push_back(mk(0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0)); // alarm ends
    vecs.push_back(mk(0,1,0,0, 8'h00,8'h00, 8'h00,8'h00, 0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].st, vecs[i].pa, vecs[i].en, vecs[i].pm, vecs[i].ps);
      cycle();
      chk($sformatf("vec%0d", i), vecs[i].eM, vecs[i].eS,
          vecs[i].eRun, vecs[i].eDone, vecs[i].eAlarm, vecs[i].eErr);
    end

    // 65 ticks from 01:05 with idle cycles between ticks
    drive(1, 0, 0, 0, 8'h01, 8'h05); cycle();
    drive(0, 1, 0, 0, 8'h00, 8'h00); cycle();
    doneCount = 0;
    for (int t = 1; t <= 65; t++) begin
      drive(0, 0, 0, 1, 8'h00, 8'h00);
      cycle();
      if (DONE) doneCount++;
      expQ = toBcd(65 - t);
      chk($sformatf("run65_tick%0d", t), expQ[15:8], expQ[7:0],
          t != 65, t == 65, t == 65, 0);
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      cycle();
      if (DONE) doneCount++;
    end
    checks++;
    if (doneCount != 1) begin
      errors++;
      $display("FAIL run65_done_pulses: got %0d expected 1", doneCount);
    end
    drive(0, 1, 0, 0, 8'h00, 8'h00); cycle();
    chk("alarm_start_ack", 8'h00, 8'h00, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 8'h00, 8'h00); cycle();
    chk("alarm_start_no_restart", 8'h00, 8'h00, 0, 0, 0, 0);

    // PAUSE acknowledges the alarm
    drive(1, 0, 0, 0, 8'h00, 8'h01); cycle();
    drive(0, 1, 0, 0, 8'h00, 8'h00); cycle();
    drive(0, 0, 0, 1, 8'h00, 8'h00); cycle();
    chk("expire_again", 8'h00, 8'h00, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 8'h00, 8'h00); cycle();
    chk("alarm_pause_ack", 8'h00, 8'h00, 0, 0, 0, 0);

    // Asynchronous reset mid-run
    drive(1, 0, 0, 0, 8'h00, 8'h30); cycle();
    drive(0, 1, 0, 0, 8'h00, 8'h00); cycle();
    drive(0, 0, 0, 1, 8'h00, 8'h00); cycle();
    cycle();
    drive(0, 0, 0, 0, 8'h00, 8'h00);
    chk("pre_reset_run", 8'h00, 8'h28, 1, 0, 0, 0);
    @(negedge CP);
    #1 nCR = 1'b0;
    #1;
    chk("async_reset_mid_run", 8'h00, 8'h00, 0, 0, 0, 0);
    #100;
    @(negedge CP);
    nCR = 1'b1;
    drive(0, 0, 0, 1, 8'h00, 8'h00); cycle();
    chk("after_reset_en_ignored", 8'h00, 8'h00, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
